// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared defaults, state encoding and CPU opcodes for the memory target
package cpu_pkg;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_CNT_W = 16;
  localparam logic [7:0] DEF_OUT_ADRS = 8'hFF;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_LD   = 8'h02;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_ST   = 8'h05;
  localparam logic [7:0] OP_JUMP = 8'h06;
endpackage

// File: rtl/mem_array_1w1r.sv
// rtl/mem_array_1w1r.sv - 2**AW x DW store, synchronous write, asynchronous read
module mem_array_1w1r #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_mem_target.sv
// rtl/cpu_mem_target.sv - CPU-side memory responder with byte-stream loader and output register
module cpu_mem_target
  import cpu_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter int            DW       = DEF_DW,
  parameter logic [AW-1:0] OUT_ADRS = AW'(DEF_OUT_ADRS),
  parameter int            CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    adrs,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [DW-1:0]    load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             cpu_rst_n,
  output logic [DW-1:0]    out_port,
  output logic             out_valid,
  output logic [CNT_W-1:0] wr_count
);
  localparam logic [AW-1:0] PTR_MAX = '1;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic            cpu_wr;
  logic            out_hit;
  logic            unused_read;

  assign unused_read = mem_read;
  assign out_hit = cpu_wr && (adrs == OUT_ADRS);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = load_data;
    cpu_wr     = 1'b0;
    load_ready = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        // load_start wins over a coincident byte: the byte is dropped
        if (load_start) begin
          ptr_d = '0;
        end else if (load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (load_last || ptr_q == PTR_MAX) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_rst_n = 1'b1;
        if (mem_write) begin
          mem_we    = 1'b1;
          mem_waddr = adrs;
          mem_wdata = wdata;
          cpu_wr    = 1'b1;
        end
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    if (rst) begin
      mem_we     = 1'b0;
      cpu_wr     = 1'b0;
      load_ready = 1'b0;
      cpu_rst_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      ptr_q     <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
      wr_count  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_valid <= out_hit;
      if (out_hit) out_port <= wdata;
      if (cpu_wr && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end

  mem_array_1w1r #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (adrs),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_cpu_mem_target.sv
// tb/tb_cpu_mem_target.sv - self-checking bench for cpu_mem_target
module tb_cpu_mem_target;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adrs, wdata, rdata, load_data, out_port;
  logic        mem_read, mem_write, load_start, load_valid, load_last;
  logic        load_ready, cpu_rst_n, out_valid;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  cpu_mem_target dut (
    .clk(clk), .rst(rst), .adrs(adrs), .wdata(wdata), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .cpu_rst_n(cpu_rst_n), .out_port(out_port),
    .out_valid(out_valid), .wr_count(wr_count)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]  ref_mem [256];
  bit          ref_known [256];
  logic [7:0]  ref_out;
  logic [15:0] ref_cnt;
  int          lptr;
  int          pulses;
  logic [7:0]  saved [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    ref_mem[lptr] = d;
    ref_known[lptr] = 1'b1;
    lptr++;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    lptr = 0;
  endtask

  task automatic peek(input string tag, input int a);
    adrs = 8'(a);
    #1;
    chk(tag, rdata, ref_mem[a]);
  endtask

  task automatic check_known();
    for (int a = 0; a < 256; a++)
      if (ref_known[a]) peek("mem", a);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    adrs = a; mem_read = 1'b1;
    #1 d = rdata;
    tick();
    mem_read = 1'b0;
    pulses += int'(out_valid);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    adrs = a; wdata = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    pulses += int'(out_valid);
    ref_mem[a] = d; ref_known[a] = 1'b1;
    if (ref_cnt != 16'hFFFF) ref_cnt++;
    if (a == 8'hFF) ref_out = d;
  endtask

  // behavioural accumulator CPU issuing one bus access per cycle
  task automatic run_cpu(input int n_instr);
    logic [7:0] pc, acc, op, opnd, tmp;
    pc = 0; acc = 0;
    for (int k = 0; k < n_instr; k++) begin
      bus_read(pc, op);
      bus_read(pc + 8'd1, opnd);
      pc = pc + 8'd2;
      case (op)
        OP_LDI:  acc = opnd;
        OP_ADDI: acc = acc + opnd;
        OP_LD:   begin bus_read(opnd, tmp); acc = tmp; end
        OP_ADD:  begin bus_read(opnd, tmp); acc = acc + tmp; end
        OP_ST:   bus_write(opnd, acc);
        OP_JUMP: pc = opnd;
        default: pc = pc;
      endcase
    end
  endtask

  initial begin
    logic [7:0] prog [8];
    logic [7:0] d, last_byte, b1;
    prog = '{OP_LDI, 8'h05, OP_ADDI, 8'h03, OP_ST, 8'hFF, OP_JUMP, 8'h06};
    rst = 1'b1; adrs = 0; wdata = 0; mem_read = 0; mem_write = 0;
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    ref_out = 0; ref_cnt = 0; lptr = 0; pulses = 0;
    for (int a = 0; a < 256; a++) ref_known[a] = 1'b0;

    tick();
    chk("ready_in_rst", load_ready, 1'b0);
    chk("cpu_rst_in_rst", cpu_rst_n, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", load_ready, 1'b1);
    chk("out_port_rst", out_port, 8'h00);
    chk("out_valid_rst", out_valid, 1'b0);
    chk("wr_count_rst", wr_count, 16'h0);

    // 8-byte image with load_last on the final byte
    for (int i = 0; i < 8; i++) begin
      chk("cpu_held_loading", cpu_rst_n, 1'b0);
      push(8'($urandom), i == 7);
    end
    chk("ready_after_last", load_ready, 1'b0);
    chk("cpu_released", cpu_rst_n, 1'b1);
    check_known();

    // load_start from RUN, then a byte coinciding with load_start is dropped
    pulse_start();
    chk("cpu_held_restart", cpu_rst_n, 1'b0);
    chk("ready_restart", load_ready, 1'b1);
    push(8'($urandom), 1'b0);
    b1 = 8'($urandom);
    push(b1, 1'b0);
    load_start = 1'b1; load_valid = 1'b1; load_data = ~b1;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    lptr = 0;
    d = 8'($urandom);
    push(d, 1'b0);
    peek("drop_first", 0);
    peek("drop_second", 1);

    // program run against the behavioural CPU
    pulse_start();
    for (int i = 0; i < 8; i++) push(prog[i], i == 7);
    chk("cpu_released_prog", cpu_rst_n, 1'b1);
    pulses = 0;
    run_cpu(6);
    tick(); pulses += int'(out_valid);
    tick(); pulses += int'(out_valid);
    chk("out_port_prog", out_port, 8'h08);
    chk("out_port_model", out_port, ref_out);
    chk("out_valid_pulses", pulses, 1);
    chk("wr_count_prog", wr_count, 16'd1);

    // full 256-byte image without load_last: ends on the wrap
    pulse_start();
    last_byte = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("ready_before_255", load_ready, 1'b1);
      last_byte = 8'($urandom);
      push(last_byte, 1'b0);
    end
    chk("run_after_256", cpu_rst_n, 1'b1);
    chk("ready_after_256", load_ready, 1'b0);
    adrs = 8'hFF; #1;
    chk("mem_255", rdata, last_byte);
    check_known();

    // same-cycle read and write returns pre-write data
    adrs = 8'h03; wdata = ~ref_mem[3]; mem_read = 1'b1; mem_write = 1'b1;
    #1 chk("rw_prewrite", rdata, ref_mem[3]);
    bus_write(8'h03, ~ref_mem[3]);
    mem_read = 1'b0;
    peek("rw_postwrite", 3);

    // drive the write counter to saturation
    while (ref_cnt != 16'hFFFE) bus_write(8'h80, 8'($urandom));
    chk("wr_count_fffe", wr_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      bus_write(8'h80 + 8'(i), 8'($urandom));
      chk("wr_count_sat", wr_count, ref_cnt);
    end
    chk("wr_count_ffff", wr_count, 16'hFFFF);
    check_known();

    // reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      saved[i] = 8'($urandom);
      push(saved[i], 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    ref_out = 0; ref_cnt = 0; lptr = 0;
    chk("out_port_midrst", out_port, 8'h00);
    chk("wr_count_midrst", wr_count, 16'h0);
    chk("ready_midrst", load_ready, 1'b1);
    chk("cpu_held_midrst", cpu_rst_n, 1'b0);
    for (int i = 0; i < 3; i++) peek("mem_kept", i);
    push(8'($urandom), 1'b0);
    push(8'($urandom), 1'b1);
    check_known();
    chk("mem2_old", ref_mem[2], saved[2]);

    // reset while running holds the CPU again
    chk("run_before_rst", cpu_rst_n, 1'b1);
    rst = 1'b1;
    tick();
    chk("cpu_held_run_rst", cpu_rst_n, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_run_rst", load_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
